traffic_phase_scheduler: RTL and testbench

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

---
 rtl/traffic_phase_scheduler.sv | 247 ++++++++++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Four-head intersection controller: main through (M1, M2), main turn (MT)
// and side street (S). It runs a fixed six-phase cycle, optionally serves a
// pedestrian walk phase, and can be preempted by an emergency request. That
// request forces an all-red clearance, then a green for the requested
// direction, then another all-red clearance.
//
// Ports
//   clk       : system clock, all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   tick      : one-cycle timebase enable; every duration is counted in ticks
//   ped_req   : pedestrian button pulse (latched as a sticky pending flag)
//   emg_req   : emergency preemption request (level)
//   emg_dir   : preempt direction 0=M1+M2, 1=MT, 2=S, 3=same as 0
//   cfg_we    : duration register write strobe
//   cfg_addr  : duration register index 0..6 (7 is ignored)
//   cfg_data  : duration value in ticks (0 behaves as 1)
//   light_*   : lamp outputs, 100=red 010=yellow 001=green
//   phase     : current state code
//   ped_walk  : high only in the pedestrian phase
//   emg_ack   : high only while the emergency green is shown
module traffic_phase_scheduler (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       emg_req,
    input  logic [1:0] emg_dir,
    input  logic       cfg_we,
    input  logic [2:0] cfg_addr,
    input  logic [3:0] cfg_data,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic [3:0] phase,
    output logic       ped_walk,
    output logic       emg_ack
);

    typedef enum logic [3:0] {
        ST_S0      = 4'd0,
        ST_S1      = 4'd1,
        ST_S2      = 4'd2,
        ST_S3      = 4'd3,
        ST_S4      = 4'd4,
        ST_S5      = 4'd5,
        ST_PED     = 4'd6,
        ST_CLR_IN  = 4'd7,
        ST_EMG     = 4'd8,
        ST_CLR_OUT = 4'd9
    } state_t;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    // Both clearance phases have a fixed length
    localparam logic [3:0] CLR_TICKS = 4'd2;

    // A programmed zero would make a phase vanish; run it for one tick instead
    function automatic logic [3:0] eff_dur(input logic [3:0] d);
        eff_dur = (d == 4'd0) ? 4'd1 : d;
    endfunction

    // Direction code 3 is folded onto the main-through pair when latched
    function automatic logic [1:0] fold_dir(input logic [1:0] d);
        fold_dir = (d == 2'd3) ? 2'd0 : d;
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            ped_pend_q, ped_pend_d;
    logic [1:0]      emg_dir_q, emg_dir_d;
    logic [6:0][3:0] dur_q, dur_d;

    logic [3:0]      cur_dur_s;
    state_t          timed_next_s;
    logic            preempt_s;

    // State, counter, flags and duration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_S0;
            cnt_q      <= 4'd1;
            ped_pend_q <= 1'b0;
            emg_dir_q  <= 2'd0;
            dur_q[0]   <= 4'd7;
            dur_q[1]   <= 4'd2;
            dur_q[2]   <= 4'd5;
            dur_q[3]   <= 4'd2;
            dur_q[4]   <= 4'd3;
            dur_q[5]   <= 4'd2;
            dur_q[6]   <= 4'd4;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ped_pend_q <= ped_pend_d;
            emg_dir_q  <= emg_dir_d;
            dur_q      <= dur_d;
        end
    end

    // Duration register write port; address 7 has no register behind it
    always_comb begin
        dur_d = dur_q;
        if (cfg_we && (cfg_addr != 3'd7)) begin
            dur_d[cfg_addr] = cfg_data;
        end else begin
            dur_d = dur_q;
        end
    end

    // Length of the current timed state, read live so writes apply at once
    always_comb begin
        cur_dur_s = CLR_TICKS;
        case (state_q)
            ST_S0:   cur_dur_s = eff_dur(dur_q[0]);
            ST_S1:   cur_dur_s = eff_dur(dur_q[1]);
            ST_S2:   cur_dur_s = eff_dur(dur_q[2]);
            ST_S3:   cur_dur_s = eff_dur(dur_q[3]);
            ST_S4:   cur_dur_s = eff_dur(dur_q[4]);
            ST_S5:   cur_dur_s = eff_dur(dur_q[5]);
            ST_PED:  cur_dur_s = eff_dur(dur_q[6]);
            default: cur_dur_s = CLR_TICKS;
        endcase
    end

    // Successor of each timed state when its duration runs out
    always_comb begin
        timed_next_s = ST_S0;
        case (state_q)
            ST_S0:     timed_next_s = ST_S1;
            ST_S1:     timed_next_s = ST_S2;
            ST_S2:     timed_next_s = ST_S3;
            ST_S3:     timed_next_s = ST_S4;
            ST_S4:     timed_next_s = ST_S5;
            ST_S5:     timed_next_s = ped_pend_q ? ST_PED : ST_S0;
            ST_PED:    timed_next_s = ST_S0;
            ST_CLR_IN: timed_next_s = ST_EMG;
            default:   timed_next_s = ST_S0;
        endcase
    end

    // CLR_OUT is excluded: a renewed request there goes straight back to EMG
    assign preempt_s = emg_req && (state_q != ST_CLR_IN) && (state_q != ST_EMG)
                       && (state_q != ST_CLR_OUT);

    // Next-state, counter and flag update; preemption outranks everything
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ped_pend_d = ped_pend_q | ped_req;
        emg_dir_d  = emg_dir_q;
        if (preempt_s) begin
            // Aborting PED leaves ped_pend as it is (already cleared on entry)
            state_d = ST_CLR_IN;
            cnt_d   = 4'd1;
        end else if (state_q == ST_EMG) begin
            if (!emg_req) begin
                state_d = ST_CLR_OUT;
                cnt_d   = 4'd1;
            end else begin
                state_d = ST_EMG;
                cnt_d   = cnt_q;
            end
        end else if ((state_q == ST_CLR_OUT) && emg_req) begin
            state_d   = ST_EMG;
            cnt_d     = 4'd1;
            emg_dir_d = fold_dir(emg_dir);
        end else if (tick) begin
            if (cnt_q < cur_dur_s) begin
                cnt_d = cnt_q + 4'd1;
            end else begin
                state_d = timed_next_s;
                cnt_d   = 4'd1;
                if (state_q == ST_CLR_IN) begin
                    emg_dir_d = fold_dir(emg_dir);
                end else begin
                    emg_dir_d = emg_dir_q;
                end
                // Entering PED consumes the request unless a new one arrives now
                if (timed_next_s == ST_PED) begin
                    ped_pend_d = ped_req;
                end else begin
                    ped_pend_d = ped_pend_q | ped_req;
                end
            end
        end else begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    // Lamp decode straight from the state register
    always_comb begin
        light_M1 = LT_RED;
        light_M2 = LT_RED;
        light_MT = LT_RED;
        light_S  = LT_RED;
        case (state_q)
            ST_S0: begin
                light_M1 = LT_GRN;
                light_M2 = LT_GRN;
            end
            ST_S1: begin
                light_M1 = LT_GRN;
                light_M2 = LT_YEL;
            end
            ST_S2: begin
                light_M1 = LT_GRN;
                light_MT = LT_GRN;
            end
            ST_S3: begin
                light_M1 = LT_YEL;
                light_MT = LT_YEL;
            end
            ST_S4: begin
                light_S = LT_GRN;
            end
            ST_S5: begin
                light_S = LT_YEL;
            end
            ST_EMG: begin
                case (emg_dir_q)
                    2'd1:    light_MT = LT_GRN;
                    2'd2:    light_S  = LT_GRN;
                    default: begin
                        light_M1 = LT_GRN;
                        light_M2 = LT_GRN;
                    end
                endcase
            end
            default: begin
                light_M1 = LT_RED;
                light_M2 = LT_RED;
                light_MT = LT_RED;
                light_S  = LT_RED;
            end
        endcase
    end

    assign phase    = state_q;
    assign ped_walk = (state_q == ST_PED);
    assign emg_ack  = (state_q == ST_EMG);

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler. Every sample packs
// {phase, M1, M2, MT, S, ped_walk, emg_ack} and compares it with a
// hand-derived expectation, one sample per clock, #1 after the rising edge.
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b1;
    logic       ped_req = 1'b0;
    logic       emg_req = 1'b0;
    logic [1:0] emg_dir = 2'd0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = 3'd0;
    logic [3:0] cfg_data = 4'd0;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic [3:0] phase;
    logic       ped_walk, emg_ack;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    localparam logic [11:0] L_S0  = {G, G, R, R};
    localparam logic [11:0] L_S1  = {G, Y, R, R};
    localparam logic [11:0] L_S2  = {G, R, G, R};
    localparam logic [11:0] L_S3  = {Y, R, Y, R};
    localparam logic [11:0] L_S4  = {R, R, R, G};
    localparam logic [11:0] L_S5  = {R, R, R, Y};
    localparam logic [11:0] L_RED = {R, R, R, R};
    localparam logic [11:0] L_EMM = {G, G, R, R};
    localparam logic [11:0] L_EMT = {R, R, G, R};
    localparam logic [11:0] L_EMS = {R, R, R, G};

    traffic_phase_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .ped_req  (ped_req),
        .emg_req  (emg_req),
        .emg_dir  (emg_dir),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .light_M1 (light_M1),
        .light_M2 (light_M2),
        .light_MT (light_MT),
        .light_S  (light_S),
        .phase    (phase),
        .ped_walk (ped_walk),
        .emg_ack  (emg_ack)
    );

    always #5 clk = ~clk;

    logic [17:0] obs_s;
    assign obs_s = {phase, light_M1, light_M2, light_MT, light_S, ped_walk, emg_ack};

    function automatic logic [17:0] expv(input logic [3:0] p, input logic [11:0] lt);
        expv = {p, lt, (p == 4'd6), (p == 4'd8)};
    endfunction

    task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect n consecutive samples in phase p, advancing one clock after each
    task automatic run_phase(input string tag, input logic [3:0] p,
                             input logic [11:0] lt, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, obs_s, expv(p, lt));
            step();
        end
    endtask

    task automatic normal_cycle(input string tag, input int s2_len);
        run_phase({tag, "_s0"}, 4'd0, L_S0, 7);
        run_phase({tag, "_s1"}, 4'd1, L_S1, 2);
        run_phase({tag, "_s2"}, 4'd2, L_S2, s2_len);
        run_phase({tag, "_s3"}, 4'd3, L_S3, 2);
        run_phase({tag, "_s4"}, 4'd4, L_S4, 3);
        run_phase({tag, "_s5"}, 4'd5, L_S5, 2);
    endtask

    initial begin
        // Reset state, before any clock edge
        #2 rst = 1'b1;
        #1 chk("reset", obs_s, expv(4'd0, L_S0));
        step();
        step();
        rst = 1'b0;

        // Default cycle, tick every clock
        normal_cycle("norm", 5);
        chk("norm_wrap", obs_s, expv(4'd0, L_S0));

        // Pedestrian request during S2 is served after S5
        run_phase("ped_s0", 4'd0, L_S0, 7);
        run_phase("ped_s1", 4'd1, L_S1, 2);
        chk("ped_s2a", obs_s, expv(4'd2, L_S2));
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        run_phase("ped_s2", 4'd2, L_S2, 4);
        run_phase("ped_s3", 4'd3, L_S3, 2);
        run_phase("ped_s4", 4'd4, L_S4, 3);
        run_phase("ped_s5", 4'd5, L_S5, 2);
        run_phase("ped_walk", 4'd6, L_RED, 4);
        normal_cycle("ped_after", 5);

        // Preemption in S0 at cnt=3, direction MT
        run_phase("emg_s0", 4'd0, L_S0, 2);
        emg_req = 1'b1;
        emg_dir = 2'd1;
        run_phase("emg_s0c3", 4'd0, L_S0, 1);
        run_phase("emg_clrin", 4'd7, L_RED, 2);
        run_phase("emg_mt", 4'd8, L_EMT, 3);
        emg_req = 1'b0;
        run_phase("emg_drop", 4'd8, L_EMT, 1);
        run_phase("emg_clrout", 4'd9, L_RED, 2);
        normal_cycle("emg_after", 5);

        // dur[2]=0 acts as one tick; address 7 writes nothing
        cfg_we   = 1'b1;
        cfg_addr = 3'd2;
        cfg_data = 4'd0;
        run_phase("cfg_w2", 4'd0, L_S0, 1);
        cfg_addr = 3'd7;
        cfg_data = 4'd1;
        run_phase("cfg_w7", 4'd0, L_S0, 1);
        cfg_we = 1'b0;
        run_phase("cfg_s0", 4'd0, L_S0, 5);
        run_phase("cfg_s1", 4'd1, L_S1, 2);
        run_phase("cfg_s2", 4'd2, L_S2, 1);
        run_phase("cfg_s3", 4'd3, L_S3, 2);
        run_phase("cfg_s4", 4'd4, L_S4, 3);
        run_phase("cfg_s5", 4'd5, L_S5, 2);

        // Pedestrian request during EMG survives the preemption
        emg_req = 1'b1;
        emg_dir = 2'd2;
        run_phase("pe_s0", 4'd0, L_S0, 1);
        run_phase("pe_clrin", 4'd7, L_RED, 2);
        ped_req = 1'b1;
        run_phase("pe_emg", 4'd8, L_EMS, 1);
        ped_req = 1'b0;
        run_phase("pe_emg", 4'd8, L_EMS, 1);
        emg_req = 1'b0;
        run_phase("pe_emg", 4'd8, L_EMS, 1);
        run_phase("pe_clrout", 4'd9, L_RED, 2);
        normal_cycle("pe_cyc", 1);
        run_phase("pe_walk", 4'd6, L_RED, 4);

        // Asynchronous reset while in EMG (direction 3 shows as M1+M2)
        emg_req = 1'b1;
        emg_dir = 2'd3;
        run_phase("ar_s0", 4'd0, L_S0, 1);
        run_phase("ar_clrin", 4'd7, L_RED, 2);
        chk("ar_emg", obs_s, expv(4'd8, L_EMM));
        #2 rst = 1'b1;
        emg_req = 1'b0;
        #1 chk("ar_async", obs_s, expv(4'd0, L_S0));
        step();
        rst = 1'b0;
        normal_cycle("ar_after", 5);

        // Drop during CLR_IN, then renewed request during CLR_OUT
        emg_req = 1'b1;
        emg_dir = 2'd0;
        run_phase("cx_s0", 4'd0, L_S0, 1);
        emg_req = 1'b0;
        run_phase("cx_clrin", 4'd7, L_RED, 2);
        run_phase("cx_emg", 4'd8, L_EMM, 1);
        emg_req = 1'b1;
        emg_dir = 2'd2;
        run_phase("cx_clrout", 4'd9, L_RED, 1);
        run_phase("cx_reemg", 4'd8, L_EMS, 1);
        emg_req = 1'b0;
        run_phase("cx_reemg", 4'd8, L_EMS, 1);
        run_phase("cx_clrout2", 4'd9, L_RED, 2);

        // Without tick the state and counter hold
        tick = 1'b0;
        run_phase("nt_hold", 4'd0, L_S0, 3);
        tick = 1'b1;
        run_phase("nt_s0", 4'd0, L_S0, 7);
        run_phase("nt_s1", 4'd1, L_S1, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
